// File: rtl/alu_sequencer.sv
// alu_sequencer: handshake front-end that drives the 16-bit 74181 ALU/shifter,
// waits for it to settle, then captures the result and keeps the C and Z flags.
module alu_sequencer #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    input  logic [3:0]  req_count,
    output logic        rsp_valid,
    output logic [15:0] rsp_result,
    output logic        rsp_err,
    output logic        flag_c,
    output logic        flag_z,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [4:0]  alu_f,
    output logic        alu_csel,
    output logic        alu_ucin,
    output logic        alu_srcin,
    output logic        alu_notALUOE,
    output logic        alu_notShiftOE,
    input  logic [15:0] alu_y,
    input  logic        alu_cout,
    input  logic        alu_zout
);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] LAST = SW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

    state_t      state;
    logic [SW-1:0] settle_cnt;
    logic [3:0]  count;
    logic        shift_op;
    logic        arith_op;
    logic        err_op;
    logic [4:0]  dec_f;
    logic        dec_shift;

    assign req_ready = state == IDLE;
    assign alu_srcin = flag_c;
    // a shift of zero runs as a single PASS step through the ALU path
    assign dec_shift = (req_op == 4'd9 || req_op == 4'd10) && req_count != 4'd0;

    always_comb begin
        dec_f = 5'b11111;
        case (req_op)
            4'd0, 4'd1: dec_f = 5'b10010;
            4'd2, 4'd3: dec_f = 5'b01100;
            4'd4:       dec_f = 5'b10111;
            4'd5:       dec_f = 5'b11101;
            4'd6:       dec_f = 5'b01101;
            4'd7:       dec_f = 5'b00001;
            4'd9:       dec_f = dec_shift ? 5'b00101 : 5'b11111;
            4'd10:      dec_f = dec_shift ? 5'b00010 : 5'b11111;
            default:    dec_f = 5'b11111;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            settle_cnt     <= '0;
            count          <= '0;
            shift_op       <= 1'b0;
            arith_op       <= 1'b0;
            err_op         <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_err        <= 1'b0;
            rsp_result     <= '0;
            flag_c         <= 1'b0;
            flag_z         <= 1'b0;
            alu_a          <= '0;
            alu_b          <= '0;
            alu_f          <= 5'b11111;
            alu_csel       <= 1'b0;
            alu_ucin       <= 1'b0;
            alu_notALUOE   <= 1'b1;
            alu_notShiftOE <= 1'b1;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    state          <= DRIVE;
                    settle_cnt     <= '0;
                    count          <= req_count;
                    shift_op       <= dec_shift;
                    arith_op       <= req_op < 4'd4;
                    err_op         <= req_op > 4'd10;
                    alu_a          <= req_a;
                    alu_b          <= req_b;
                    alu_f          <= dec_f;
                    alu_csel       <= req_op == 4'd1 || req_op == 4'd3;
                    alu_ucin       <= req_op == 4'd2;
                    alu_notALUOE   <= dec_shift;
                    alu_notShiftOE <= !dec_shift;
                end
                DRIVE: if (settle_cnt == LAST) begin
                    settle_cnt <= '0;
                    rsp_result <= alu_y;
                    flag_z     <= alu_zout;
                    if (arith_op || shift_op) flag_c <= alu_cout;
                    if (shift_op && count != 4'd1) begin
                        count <= count - 4'd1;
                        alu_a <= alu_y;
                    end else begin
                        state          <= RESP;
                        rsp_valid      <= 1'b1;
                        rsp_err        <= err_op;
                        alu_notALUOE   <= 1'b1;
                        alu_notShiftOE <= 1'b1;
                    end
                end else begin
                    settle_cnt <= settle_cnt + 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Synchronous front-end that issues operations to the 16-bit 74181-based ALU/shifter datapath and captures its results.
- Accepts an operation request through a valid/ready handshake.
- Drives the ALU operands, function code, carry-select and active-low output enables.
- Samples the ALU's y/cout/zout after a settle window and keeps the architectural C and Z flags.
- Multi-bit shifts run as repeated single-bit passes through the ALU shift path.

Parameters:
SETTLE_CYCLES, 1, cycles an ALU output enable is held low before y/cout/zout are sampled (>=1)

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  high only in IDLE
req_op  input  4  0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 AND, 5 OR, 6 XOR, 7 NOT, 8 PASS, 9 SHL, 10 SHR, 11-15 illegal
req_a  input  16  operand A
req_b  input  16  operand B (ignored for NOT/PASS/SHL/SHR)
req_count  input  4  shift amount for SHL/SHR
rsp_valid  output  1  one-cycle pulse, result and flags valid
rsp_result  output  16  captured result, held until next capture
rsp_err  output  1  high with rsp_valid for an illegal opcode
flag_c  output  1  carry flag (srcin source)
flag_z  output  1  zero flag
alu_a  output  16  to ALU a (working register)
alu_b  output  16  to ALU b
alu_f  output  5  to ALU f = {S3,S2,S1,S0,M}
alu_csel  output  1  0 selects ucin, 1 selects srcin as carry-in
alu_ucin  output  1  immediate carry-in
alu_srcin  output  1  always equals flag_c
alu_notALUOE  output  1  active-low ALU output enable
alu_notShiftOE  output  1  active-low shifter output enable
alu_y  input  16  ALU bus result
alu_cout  input  1  ALU carry out (active high)
alu_zout  input  1  ALU zero out (active high)

Behaviour:
- FSM states are IDLE, DRIVE, RESP.
  - IDLE: req_ready=1. req_valid=1 latches op, a, b and count, then goes to DRIVE.
  - DRIVE: holds the matching OE low for SETTLE_CYCLES cycles. The last DRIVE edge samples alu_y/alu_cout/alu_zout.
    - Non-shift op: go to RESP.
    - Shift op: decrement the remaining count. If the count is >0, re-enter DRIVE with alu_a = the captured y. Otherwise go to RESP.
  - RESP: rsp_valid=1, req_ready=0. Next state is IDLE.
- Latency from the accept edge to rsp_valid:
  - non-shift ops: SETTLE_CYCLES+1 edges
  - shift with count N>=1: N*SETTLE_CYCLES+1 edges
- Output enables:
  - Both OEs are high outside DRIVE.
  - The two OEs are never low together.
  - alu_f, alu_a, alu_b and csel are stable throughout DRIVE.
- Encodings (f, csel, ucin, then flag effect):
  - ADD: f=10010, csel=0, ucin=0
  - ADC: f=10010, csel=1
  - SUB: f=01100, csel=0, ucin=1
  - SBC: f=01100, csel=1. flag_c=1 means no borrow.
  - AND: f=10111
  - OR: f=11101
  - XOR: f=01101
  - NOT: f=00001
  - PASS: f=11111
  - SHL: f=00101, notShiftOE=0
  - SHR: f=00010, notShiftOE=0
  - Illegal opcodes execute as PASS and assert rsp_err.
- Flag rules:
  - flag_z = alu_zout at every capture.
  - flag_c:
    - Arithmetic ops: flag_c = alu_cout.
    - Shift ops: flag_c = alu_cout at each step, so the last bit shifted out remains.
    - Logic ops, PASS and illegal opcodes: flag_c unchanged.
  - alu_srcin follows flag_c combinationally from the register. Within a shift loop it therefore reflects the previous step.
- Shift with count=0 executes as PASS of A for one step: flag_c unchanged, flag_z updated, no rsp_err.
- alu_notALUOE=0 for all non-shift ops during DRIVE. alu_notShiftOE=0 for SHL/SHR during DRIVE.
- req_valid while busy is ignored; the requester must hold it until req_ready.
- Back-to-back: a request presented during RESP is accepted in the following IDLE cycle.
- Reset (any state, including mid-shift):
  - State goes to IDLE and both OEs go high.
  - rsp_valid=0, rsp_err=0, rsp_result=0, flag_c=0, flag_z=0.
  - alu_a=0, alu_b=0, alu_f=11111, csel=0, ucin=0.
  - No response is issued for an aborted op.

Test Plan:
- ADD a=7FFF b=0001 -> rsp_result=8000, flag_c=0, flag_z=0; rsp_valid 2 edges after accept (SETTLE_CYCLES=1).
- SUB 0005-0005 -> 0000, flag_c=1, flag_z=1. Then SBC 0005-0003 with flag_c forced 0 via prior SUB 0000-0001 (expect FFFF, C=0) -> result 0001, C=1.
- SHL a=8001 count=3 -> 0008, flag_c=0 (step carries 1,0,0). rsp_valid 4 edges after accept. alu_notALUOE stays 1 throughout.
- SHR a=0005 count=1 -> 0002, flag_c=1. SHL count=0 a=0000 -> 0000, flag_z=1, flag_c unchanged.
- AND FF00&0FF0 -> 0F00, flag_c unchanged. Opcode 13 a=1234 -> 1234, rsp_err=1.
- Assert reset on the 2nd DRIVE cycle of SHL count=5 -> next cycle IDLE, both OEs 1, flags 0, no rsp_valid. A following ADD 0001+0001 -> 0002.
